// File: rtl/led_pattern_engine.sv
// LED pattern engine: prescaled (or single-stepped) advance ticks drive a
// one-hot rotate, ping-pong, bar-fill or blink-all pattern on NUM_LEDS LEDs.
module led_pattern_engine #(
  parameter int NUM_LEDS = 7,
  parameter int DIV_W    = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                step,
  input  logic [1:0]          mode,
  input  logic                dir,
  input  logic [DIV_W-1:0]    div_max,
  output logic [NUM_LEDS-1:0] led,
  output logic                tick,
  output logic                wrap
);

  localparam int PW = $clog2(NUM_LEDS + 1);
  localparam logic [PW-1:0]       POS_MAX = PW'(NUM_LEDS);
  localparam logic [NUM_LEDS-1:0] ONE     = {{(NUM_LEDS-1){1'b0}}, 1'b1};
  localparam logic [NUM_LEDS-1:0] TOP     = {1'b1, {(NUM_LEDS-1){1'b0}}};
  localparam logic [NUM_LEDS-1:0] ALL     = {NUM_LEDS{1'b1}};

  typedef enum logic [1:0] {
    SHIFT  = 2'b00,
    BOUNCE = 2'b01,
    FILL   = 2'b10,
    BLINK  = 2'b11
  } mode_e;

  logic [DIV_W-1:0]    cnt;
  logic [PW-1:0]       pos;
  mode_e               mode_q;
  logic                bounce_up;
  logic                adv;
  logic [NUM_LEDS-1:0] shift_nxt;
  logic                bnc_go_up;
  logic [NUM_LEDS-1:0] bnc_nxt;
  logic                fill_last;
  logic [PW-1:0]       pos_inc;

  // Bar of k lit LEDs, packed from bit0 (d=0) or from the top LED (d=1).
  function automatic logic [NUM_LEDS-1:0] fill_pat(input logic [PW-1:0] k, input logic d);
    logic [NUM_LEDS-1:0] p;
    p = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (d) p[i] = (i >= (NUM_LEDS - int'(k)));
      else   p[i] = (i < int'(k));
    end
    return p;
  endfunction

  // First pattern shown when a mode is (re)entered.
  function automatic logic [NUM_LEDS-1:0] start_pat(input mode_e m, input logic d);
    logic [NUM_LEDS-1:0] p;
    case (m)
      SHIFT:   p = d ? TOP : ONE;
      BOUNCE:  p = ONE;
      FILL:    p = '0;
      default: p = ALL;
    endcase
    return p;
  endfunction

  // Advance source and next-pattern candidates for the current LED state.
  always_comb begin
    adv       = enable ? (cnt >= div_max) : step;
    shift_nxt = dir ? {led[0], led[NUM_LEDS-1:1]} : {led[NUM_LEDS-2:0], led[NUM_LEDS-1]};
    // Forced upward from bit0 and downward from the top so a stale flag cannot stall the walk.
    bnc_go_up = led[0] | (bounce_up & ~led[NUM_LEDS-1]);
    bnc_nxt   = bnc_go_up ? {led[NUM_LEDS-2:0], 1'b0} : {1'b0, led[NUM_LEDS-1:1]};
    fill_last = (pos >= POS_MAX);
    pos_inc   = pos + 1'b1;
  end

  // Prescaler: free-runs while enabled, frozen otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= adv ? '0 : cnt + 1'b1;
    end
  end

  // Pattern state machine: mode/dir are only looked at on advance edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos       <= '0;
      mode_q    <= SHIFT;
      bounce_up <= 1'b1;
      led       <= ONE;
      tick      <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      tick <= adv;
      wrap <= 1'b0;
      if (adv) begin
        if (mode_e'(mode) != mode_q) begin
          mode_q    <= mode_e'(mode);
          pos       <= '0;
          bounce_up <= 1'b1;
          led       <= start_pat(mode_e'(mode), dir);
        end else begin
          case (mode_q)
            SHIFT: begin
              led  <= shift_nxt;
              wrap <= (shift_nxt == (dir ? TOP : ONE));
            end
            BOUNCE: begin
              led       <= bnc_nxt;
              bounce_up <= bnc_go_up ? ~bnc_nxt[NUM_LEDS-1] : bnc_nxt[0];
              wrap      <= ~bnc_go_up & (bnc_nxt == ONE);
            end
            FILL: begin
              if (fill_last) begin
                pos  <= '0;
                led  <= '0;
                wrap <= 1'b1;
              end else begin
                pos <= pos_inc;
                led <= fill_pat(pos_inc, dir);
              end
            end
            default: begin
              if (&led) begin
                led <= '0;
              end else begin
                led  <= ALL;
                wrap <= 1'b1;
              end
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed bench for led_pattern_engine (NUM_LEDS=7, DIV_W=4).
module tb_led_pattern_engine;

  localparam int N  = 7;
  localparam int DW = 4;

  localparam logic [N-1:0] T2_SEQ [7]  = '{7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40, 7'h01};
  localparam logic [N-1:0] T3_SEQ [12] = '{7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40,
                                           7'h20, 7'h10, 7'h08, 7'h04, 7'h02, 7'h01};
  localparam logic [N-1:0] T4_SEQ [8]  = '{7'h40, 7'h60, 7'h70, 7'h78, 7'h7C, 7'h7E, 7'h7F, 7'h00};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          step;
  logic [1:0]    mode;
  logic          dir;
  logic [DW-1:0] div_max;
  logic [N-1:0]  led;
  logic          tick;
  logic          wrap;

  int checks = 0;
  int errors = 0;
  int nt;

  led_pattern_engine #(.NUM_LEDS(N), .DIV_W(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .step    (step),
    .mode    (mode),
    .dir     (dir),
    .div_max (div_max),
    .led     (led),
    .tick    (tick),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_adv(input string tag, input logic [N-1:0] l, input logic w);
    chk({tag, ".led"}, 32'(led), 32'(l));
    chk({tag, ".tick"}, 32'(tick), 32'd1);
    chk({tag, ".wrap"}, 32'(wrap), 32'(w));
  endtask

  initial begin
    rst_n   = 1'b0;
    enable  = 1'b0;
    step    = 1'b0;
    mode    = 2'b00;
    dir     = 1'b0;
    div_max = 4'd3;
    cyc(2);
    chk("rst.led", 32'(led), 32'h01);
    chk("rst.tick", 32'(tick), 32'd0);
    chk("rst.wrap", 32'(wrap), 32'd0);

    // T1: first tick div_max+1 edges after release, then async reset mid-count
    rst_n  = 1'b1;
    enable = 1'b1;
    cyc(3);
    chk("t1.early_tick", 32'(tick), 32'd0);
    chk("t1.early_led", 32'(led), 32'h01);
    cyc(1);
    chk_adv("t1.first", 7'h02, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("t1.async_led", 32'(led), 32'h01);
    chk("t1.async_tick", 32'(tick), 32'd0);
    chk("t1.async_wrap", 32'(wrap), 32'd0);
    cyc(1);
    rst_n = 1'b1;

    // T2: SHIFT left every 4 clocks, wrap on 40->01
    for (int k = 0; k < 7; k++) begin
      cyc(3);
      chk("t2.gap_tick", 32'(tick), 32'd0);
      cyc(1);
      chk_adv("t2.shift", T2_SEQ[k], (k == 6));
    end
    cyc(4);
    chk_adv("t2.pre_dir1", 7'h02, 1'b0);
    cyc(4);
    chk_adv("t2.pre_dir2", 7'h04, 1'b0);
    dir = 1'b1;
    cyc(4);
    chk_adv("t2.dir_rev", 7'h02, 1'b0);
    cyc(4);
    chk_adv("t2.dir_rev2", 7'h01, 1'b0);
    cyc(4);
    chk_adv("t2.dir_wrap", 7'h40, 1'b1);

    // T3: BOUNCE every cycle, reload to bit0 first
    mode    = 2'b01;
    div_max = 4'd0;
    dir     = 1'b0;
    cyc(1);
    chk_adv("t3.reload", 7'h01, 1'b0);
    for (int k = 0; k < 12; k++) begin
      cyc(1);
      chk_adv("t3.bounce", T3_SEQ[k], (k == 11));
    end
    cyc(1);
    chk_adv("t3.again", 7'h02, 1'b0);

    // T4: FILL from the top, then BLINK
    mode = 2'b10;
    dir  = 1'b1;
    cyc(1);
    chk_adv("t4.reload", 7'h00, 1'b0);
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      chk_adv("t4.fill", T4_SEQ[k], (k == 7));
    end
    mode = 2'b11;
    cyc(1);
    chk_adv("t4.blink_reload", 7'h7F, 1'b0);
    cyc(1);
    chk_adv("t4.blink_off", 7'h00, 1'b0);
    cyc(1);
    chk_adv("t4.blink_on", 7'h7F, 1'b1);

    // T5: manual steps with prescaler frozen at cnt=3
    div_max = 4'd9;
    cyc(3);
    chk("t5.no_tick", 32'(tick), 32'd0);
    enable = 1'b0;
    nt = 0;
    for (int s = 0; s < 3; s++) begin
      step = 1'b1;
      cyc(1);
      nt += int'(tick);
      step = 1'b0;
      for (int j = 0; j < 4; j++) begin
        cyc(1);
        nt += int'(tick);
      end
    end
    chk("t5.tick_count", 32'(nt), 32'd3);
    chk("t5.led", 32'(led), 32'h00);
    chk("t5.cnt_frozen", 32'(dut.cnt), 32'd3);
    enable = 1'b1;
    step   = 1'b1;
    cyc(1);
    step = 1'b0;
    chk("t5.step_ignored_tick", 32'(tick), 32'd0);
    chk("t5.step_ignored_led", 32'(led), 32'h00);

    // T6: lower div_max below the running count
    div_max = 4'd15;
    cyc(5);
    chk("t6.cnt9", 32'(dut.cnt), 32'd9);
    div_max = 4'd2;
    cyc(1);
    chk_adv("t6.immediate", 7'h7F, 1'b1);
    cyc(2);
    chk("t6.gap_tick", 32'(tick), 32'd0);
    cyc(1);
    chk_adv("t6.period1", 7'h00, 1'b0);
    cyc(3);
    chk_adv("t6.period2", 7'h7F, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
